// File: rtl/mac_pkg.sv
// Shared defaults, data types and helpers for the signed multiply-accumulate stage.
package mac_pkg;

    localparam int ACC_W_DEFAULT = 72;
    localparam int CNT_W_DEFAULT = 16;
    localparam int OPERAND_W     = 32;
    localparam int PRODUCT_W     = 64;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic signed [PRODUCT_W-1:0] product_t;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Two's-complement add overflow: both addends share a sign the sum does not carry.
    function automatic logic add_overflow(
        input logic a_sign,
        input logic b_sign,
        input logic sum_sign
    );
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational signed 32x32 multiplier producing a full 64-bit two's-complement product.
module mac_mult
    import mac_pkg::*;
(
    input  operand_t op_a,
    input  operand_t op_b,
    output product_t product
);

    assign product = product_t'(op_a) * product_t'(op_b);

endmodule

// File: rtl/mac_accumulator.sv
// Three-stage pipelined signed multiply-accumulate with per-batch results and
// valid/ready handshakes; a stalled output freezes the whole pipeline.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             IN_VALID_i,
    output logic             IN_READY_o,
    input  logic [31:0]      DIN1_i,
    input  logic [31:0]      DIN2_i,
    input  logic             LAST_i,
    output logic             OUT_VALID_o,
    input  logic             OUT_READY_i,
    output logic [ACC_W-1:0] DOUT_o,
    output logic [CNT_W-1:0] COUNT_o,
    output logic             OVF_o
);

    out_state_e              state_r;
    out_state_e              state_next_s;
    logic                    stall_s;
    logic                    load_s;
    logic                    accum_s;

    operand_t                a_r;
    operand_t                b_r;
    logic                    last1_r;
    logic                    v1_r;

    product_t                prod_s;
    product_t                p_r;
    logic                    last2_r;
    logic                    v2_r;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    ovf_r;
    logic                    ovf_add_s;
    logic                    ovf_next_s;

    logic [ACC_W-1:0]        dout_r;
    logic [CNT_W-1:0]        count_r;
    logic                    ovf_out_r;

    // Only an unconsumed result that the sink refuses can stall the pipe.
    always_comb begin
        stall_s = (state_r == OUT_FULL) && !OUT_READY_i;
        accum_s = !stall_s && v2_r && !last2_r;
        load_s  = !stall_s && v2_r && last2_r;
    end

    assign IN_READY_o  = !stall_s;
    assign OUT_VALID_o = (state_r == OUT_FULL);
    assign DOUT_o      = dout_r;
    assign COUNT_o     = count_r;
    assign OVF_o       = ovf_out_r;

    // S1: operand register; bubbles enter as v=0 entries.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            a_r     <= '0;
            b_r     <= '0;
            last1_r <= 1'b0;
            v1_r    <= 1'b0;
        end else if (!stall_s) begin
            a_r     <= operand_t'(DIN1_i);
            b_r     <= operand_t'(DIN2_i);
            last1_r <= LAST_i;
            v1_r    <= IN_VALID_i;
        end
    end

    mac_mult u_mult (
        .op_a    (a_r),
        .op_b    (b_r),
        .product (prod_s)
    );

    // S2: product register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            p_r     <= '0;
            last2_r <= 1'b0;
            v2_r    <= 1'b0;
        end else if (!stall_s) begin
            p_r     <= prod_s;
            last2_r <= last1_r;
            v2_r    <= v1_r;
        end
    end

    // Guarded add of the sign-extended product, sticky overflow and saturating term count.
    always_comb begin
        p_ext_s    = ACC_W'(p_r);
        sum_s      = acc_r + p_ext_s;
        ovf_add_s  = add_overflow(acc_r[ACC_W-1], p_ext_s[ACC_W-1], sum_s[ACC_W-1]);
        ovf_next_s = ovf_r | ovf_add_s;
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1'b1);
        end
    end

    // S3 accumulator: grows on non-last terms, restarts once a batch closes.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (accum_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_next_s;
        end else if (load_s) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end
    end

    // Output buffer next state; a load coinciding with a drain keeps it full.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            OUT_EMPTY: begin
                if (load_s) begin
                    state_next_s = OUT_FULL;
                end else begin
                    state_next_s = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (load_s) begin
                    state_next_s = OUT_FULL;
                end else if (OUT_READY_i) begin
                    state_next_s = OUT_EMPTY;
                end else begin
                    state_next_s = OUT_FULL;
                end
            end
            default: state_next_s = OUT_EMPTY;
        endcase
    end

    // Output buffer state register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_r <= OUT_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result register: captures the closing sum; otherwise holds steady.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            dout_r    <= '0;
            count_r   <= '0;
            ovf_out_r <= 1'b0;
        end else if (load_s) begin
            dout_r    <= sum_s;
            count_r   <= cnt_inc_s;
            ovf_out_r <= ovf_next_s;
        end
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Pipelined signed 32x32 multiply-accumulate stage with valid/ready handshakes on input and output. Accepts a stream of operand pairs grouped into batches by a LAST flag. Each product comes from a combinational signed multiplier, which produces a 64-bit two's-complement result. The block sums all products in a batch into a guarded accumulator and emits one result per batch. It sits between the operand source (register file / DMA feeder) and the result sink.

## Interface
- ACC_W, 72: accumulator and output width; legal range 64..96; guard bits = ACC_W-64.
- CNT_W, 16: width of the batch term counter.
- CLK_i  in  1  clock; all state changes on the rising edge.
- RST_i  in  1  synchronous, active-high reset.
- IN_VALID_i  in  1  operand pair and LAST_i are valid.
- IN_READY_o  out  1  block accepts the operand pair this cycle.
- DIN1_i  in  32  signed multiplicand.
- DIN2_i  in  32  signed multiplier.
- LAST_i  in  1  this pair closes the current batch.
- OUT_VALID_o  out  1  result register holds an unconsumed batch result.
- OUT_READY_i  in  1  sink takes the result this cycle.
- DOUT_o  out  ACC_W  signed batch sum.
- COUNT_o  out  CNT_W  number of terms in the reported batch; saturates at all-ones.
- OVF_o  out  1  sticky: signed overflow of the ACC_W accumulator occurred during the reported batch.

## Operation
- Decided: one clock; reset is synchronous and active-high.
- Handshakes:
  - Input beat transfers on an edge where IN_VALID_i && IN_READY_o.
  - Output beat transfers on an edge where OUT_VALID_o && OUT_READY_i.
  - IN_VALID_i must not wait for IN_READY_o. Inputs may change freely when not valid.
- stall = OUT_VALID_o && !OUT_READY_i.
- IN_READY_o = !stall. This is combinational from OUT_READY_i and registered state only.
- When stall=1, all pipeline registers hold.
- Pipeline:
  - S1: operand register {a, b, last, v}.
  - S2: product register {p[63:0], last, v}, where p = multiplier(S1.a, S1.b).
  - S3: accumulator {acc, cnt, ovf} plus the output register.
- Bubbles (IN_VALID_i low) advance as v=0 entries and do not touch the accumulator.
- S2 valid, not last:
  - acc += sext(p).
  - cnt += 1, saturating.
  - ovf |= signed overflow of that add.
- S2 valid, last:
  - Load DOUT_o = acc + sext(p), COUNT_o = cnt+1 (saturating), OVF_o = ovf | overflow.
  - Set OUT_VALID_o.
  - Clear acc, cnt and ovf to 0 for the next batch.
- Overflow detection: operand signs equal and result sign differs. The sum wraps modulo 2^ACC_W and is not saturated.
- Output buffer FSM:
  - EMPTY -> FULL on a last-load.
  - FULL -> EMPTY on output transfer with no simultaneous load.
  - FULL -> FULL when an output transfer and a last-load coincide; the new result replaces the old one.
- A single-beat batch (LAST_i on the first pair) yields DOUT_o = sext(product), COUNT_o = 1.
- Reset mid-batch or mid-stall: the partial batch and any pending result are discarded.

## Timing
- Reset values:
  - IN_READY_o = 1, OUT_VALID_o = 0, DOUT_o = 0, COUNT_o = 0, OVF_o = 0.
  - All stage valids 0; acc, cnt and ovf 0.
- Latency: the last beat is accepted on edge N; OUT_VALID_o is high after edge N+2, assuming no stall.
- Throughput: one pair per cycle while the output is drained every cycle.
- Back-to-back single-beat batches yield one result per cycle.
- Output holds DOUT_o, COUNT_o and OVF_o stable while OUT_VALID_o && !OUT_READY_i.
- IN_READY_o drops in the same cycle the stall begins and rises in the cycle OUT_READY_i is seen high.

## Structure
- Package mac_pkg:
  - ACC_W and CNT_W defaults.
  - operand_t (logic signed [31:0]), product_t (logic signed [63:0]).
  - out_state_e {OUT_EMPTY, OUT_FULL}.
- One sub-module: the existing combinational signed multiplier, instantiated once between S1 and S2.
- Everything else is inline: stage registers, accumulator adder, output FSM.

## Test plan
- Batch (3,4), (-5,6, LAST) with OUT_READY_i=1 -> DOUT_o = -18 (0xFF_FFFF_FFFF_FFFF_FFEE), COUNT_o = 2, OVF_o = 0, OUT_VALID_o high exactly 2 edges after the last accept.
- Single-beat (0x80000000, 0x80000000, LAST) -> DOUT_o = 0x00_4000_0000_0000_0000, COUNT_o = 1.
- ACC_W=64: batch (0x80000000, 0x80000000), (0x80000000, 0x80000000, LAST) -> DOUT_o = 0x8000_0000_0000_0000, OVF_o = 1. The next batch (1, 1, LAST) reports OVF_o = 0.
- Backpressure:
  - Setup: OUT_READY_i=0; four consecutive single-beat batches (1,1), (2,2), (3,3), (4,4) presented with IN_VALID_i held high.
  - While stalled: first result 1 held, IN_READY_o=0, inputs held.
  - After releasing OUT_READY_i: results 1, 4, 9, 16 arrive in order, none lost or duplicated.
- Random IN_VALID_i bubbles and OUT_READY_i toggling over 1000 random batches -> results match a reference model (sum, count, overflow).
- RST_i pulsed after 2 beats of batch (7,7), (7,7), then batch (2,3, LAST) -> all outputs 0 during reset; next result DOUT_o = 6, COUNT_o = 1.
